hilo_divider: RTL

Iterative multi-cycle divider for DIV/DIVU, sitting in the execute stage between the decode/execute pipeline register and the execute/memory pipeline register. It produces the 64-bit {remainder, quotient} word that travels with the ALU 64-bit result toward HI/LO write-back. It raises Busy so the hazard logic can stall fetch and decode while a division is in flight.

---
 rtl/hilo_div_pkg.sv | 15 +
 rtl/hilo_divider_if.sv | 27 ++
 rtl/hilo_divider_div_step.sv | 28 ++
 rtl/hilo_divider.sv | 106 ++++++++++
 4 files changed

// File: rtl/hilo_div_pkg.sv
// Shared definitions for the HI/LO iterative divider: state encoding,
// operand width and the fixed Start-to-Done latency used for stall checks.
package hilo_div_pkg;

  localparam int unsigned DIV_WIDTH   = 32;
  localparam int unsigned DIV_LATENCY = DIV_WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } divState_t;

endpackage

// File: rtl/hilo_divider_if.sv
// Request/result bundle between the execute stage and the HI/LO divider.
interface hilo_divider_if
  import hilo_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) ();

  logic               Start;
  logic               Signed;
  logic [WIDTH-1:0]   Dividend;
  logic [WIDTH-1:0]   Divisor;
  logic               Busy;
  logic               Done;
  logic               DivZero;
  logic [2*WIDTH-1:0] Result64;

  modport master (
    output Start, Signed, Dividend, Divisor,
    input  Busy, Done, DivZero, Result64
  );

  modport slave (
    input  Start, Signed, Dividend, Divisor,
    output Busy, Done, DivZero, Result64
  );

endinterface

// File: rtl/hilo_divider_div_step.sv
// One combinational restoring-division iteration on {rem, quo}.
module div_step
  import hilo_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   remIn,
  input  logic [WIDTH-1:0] quoIn,
  input  logic [WIDTH-1:0] dvsMag,
  output logic [WIDTH:0]   remOut,
  output logic [WIDTH-1:0] quoOut
);

  logic [WIDTH+1:0] diff;

  always_comb begin
    // Extra top bit catches the borrow of the trial subtract.
    diff = {remIn, quoIn[WIDTH-1]} - {2'b00, dvsMag};
    if (diff[WIDTH+1]) begin
      remOut = {remIn[WIDTH-1:0], quoIn[WIDTH-1]};
      quoOut = {quoIn[WIDTH-2:0], 1'b0};
    end else begin
      remOut = diff[WIDTH:0];
      quoOut = {quoIn[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/hilo_divider.sv
// Fixed-latency DIV/DIVU unit: magnitudes are divided with a restoring loop,
// then signs are fixed up and {remainder, quotient} is registered for HI/LO.
module hilo_divider
  import hilo_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic          Clk,
  input  logic          Rst,
  hilo_divider_if.slave divBus
);

  localparam int unsigned CW = $clog2(WIDTH);

  divState_t          state;
  logic               dvdNeg;
  logic               dvsNeg;
  logic [WIDTH-1:0]   dvsMag;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   quo;
  logic [CW-1:0]      count;
  logic               busyQ;
  logic               doneQ;
  logic               divZeroQ;
  logic [2*WIDTH-1:0] resultQ;

  logic [WIDTH:0]     nextRem;
  logic [WIDTH-1:0]   nextQuo;
  logic [WIDTH-1:0]   absDvd;
  logic [WIDTH-1:0]   absDvs;
  logic [WIDTH-1:0]   quoFix;
  logic [WIDTH-1:0]   remFix;
  logic               dvsZero;

  div_step #(.WIDTH(WIDTH)) stepInst (
    .remIn  (rem),
    .quoIn  (quo),
    .dvsMag (dvsMag),
    .remOut (nextRem),
    .quoOut (nextQuo)
  );

  always_comb begin
    absDvd  = (divBus.Signed && divBus.Dividend[WIDTH-1]) ? -divBus.Dividend : divBus.Dividend;
    absDvs  = (divBus.Signed && divBus.Divisor[WIDTH-1])  ? -divBus.Divisor  : divBus.Divisor;
    dvsZero = (dvsMag == '0);
    // With a zero divisor the loop leaves quo all ones and rem = |Dividend|,
    // so only the quotient fix-up is skipped; negating rem restores Dividend.
    quoFix  = ((dvdNeg ^ dvsNeg) && !dvsZero) ? -quo : quo;
    remFix  = dvdNeg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= S_IDLE;
      dvdNeg   <= 1'b0;
      dvsNeg   <= 1'b0;
      dvsMag   <= '0;
      rem      <= '0;
      quo      <= '0;
      count    <= '0;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
      divZeroQ <= 1'b0;
      resultQ  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          doneQ <= 1'b0;
          if (divBus.Start) begin
            dvdNeg <= divBus.Signed & divBus.Dividend[WIDTH-1];
            dvsNeg <= divBus.Signed & divBus.Divisor[WIDTH-1];
            dvsMag <= absDvs;
            quo    <= absDvd;
            rem    <= '0;
            count  <= '0;
            busyQ  <= 1'b1;
            state  <= S_RUN;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_RUN: begin
          rem   <= nextRem;
          quo   <= nextQuo;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= S_FIX;
        end
        S_FIX: begin
          resultQ  <= {remFix, quoFix};
          divZeroQ <= dvsZero;
          busyQ    <= 1'b0;
          doneQ    <= 1'b1;
          state    <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign divBus.Busy     = busyQ;
  assign divBus.Done     = doneQ;
  assign divBus.DivZero  = divZeroQ;
  assign divBus.Result64 = resultQ;

endmodule
